// File: rtl/multi_port_phys_reg_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_port_phys_reg_file_pkg                                             |
// | Shared register-file types, defaults and the init-state encoding.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package multi_port_phys_reg_file_pkg;

   localparam int PSCALAR_NUM     = 64;
   localparam int PREG_DATA_WIDTH = 33;

   typedef enum logic [0:0] {
      RF_INIT  = 1'b0,
      RF_READY = 1'b1
   } rf_init_state_t;

   // Cycles needed to zero `entries` locations using `ports` writes per cycle.
   function automatic int unsigned init_cycles(int unsigned entries, int unsigned ports);
      return (entries + ports - 1) / ports;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_phys_reg_file_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_port_phys_reg_file_if                                              |
// | Read/write/init bus between the pipeline stages and the register file.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface multi_port_phys_reg_file_if #(
   parameter int ENTRY_NUM  = 64,
   parameter int DATA_WIDTH = 33,
   parameter int READ_NUM   = 8,
   parameter int WRITE_NUM  = 4
);
   localparam int AW = $clog2(ENTRY_NUM);

   logic                                  initStart;
   logic                                  initBusy;
   logic                                  initDone;
   logic                                  wrConflict;
   logic [WRITE_NUM-1:0]                  we;
   logic [WRITE_NUM-1:0][AW-1:0]          wa;
   logic [WRITE_NUM-1:0][DATA_WIDTH-1:0]  wv;
   logic [READ_NUM-1:0][AW-1:0]           ra;
   logic [READ_NUM-1:0][DATA_WIDTH-1:0]   rv;

   modport master (
      output initStart, we, wa, wv, ra,
      input  initBusy, initDone, wrConflict, rv
   );

   modport slave (
      input  initStart, we, wa, wv, ra,
      output initBusy, initDone, wrConflict, rv
   );
endinterface
`default_nettype wire

// File: rtl/multi_port_phys_reg_file_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_port_phys_reg_file_ram                                             |
// | Multi-port storage: synchronous writes, asynchronous reads.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multi_port_phys_reg_file_ram #(
   parameter int ENTRY_NUM  = 64,
   parameter int DATA_WIDTH = 33,
   parameter int READ_NUM   = 8,
   parameter int WRITE_NUM  = 4,
   parameter int AW         = $clog2(ENTRY_NUM)
) (
   input  logic                                 clk,
   input  logic [WRITE_NUM-1:0]                 we,
   input  logic [WRITE_NUM-1:0][AW-1:0]         wa,
   input  logic [WRITE_NUM-1:0][DATA_WIDTH-1:0] wv,
   input  logic [READ_NUM-1:0][AW-1:0]          ra,
   output logic [READ_NUM-1:0][DATA_WIDTH-1:0]  rv
);

   logic [DATA_WIDTH-1:0] mem_q [ENTRY_NUM];

   // Callers guarantee enabled write addresses are in range and unique.
   always_ff @(posedge clk) begin
      for (int p = 0; p < WRITE_NUM; p++) begin
         if (we[p]) begin
            mem_q[wa[p]] <= wv[p];
         end
      end
   end

   always_comb begin
      rv = '0;
      for (int i = 0; i < READ_NUM; i++) begin
         if (32'(ra[i]) < ENTRY_NUM) begin
            rv[i] = mem_q[ra[i]];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/multi_port_phys_reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_port_phys_reg_file                                                 |
// | N-read/M-write physical register file with self-sequenced zero init.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multi_port_phys_reg_file
   import multi_port_phys_reg_file_pkg::*;
#(
   parameter int ENTRY_NUM    = PSCALAR_NUM,
   parameter int DATA_WIDTH   = PREG_DATA_WIDTH,
   parameter int READ_NUM     = 8,
   parameter int WRITE_NUM    = 4,
   parameter int READ_LATENCY = 1,
   parameter int BYPASS_EN    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   multi_port_phys_reg_file_if.slave bus
);

   localparam int AW = $clog2(ENTRY_NUM);
   localparam int IW = $clog2(ENTRY_NUM + WRITE_NUM) + 1;

   rf_init_state_t                        state_q, state_d;
   logic [IW-1:0]                         init_idx_q, init_idx_d;
   logic                                  wr_conflict_q, wr_conflict_d;
   logic                                  init_busy;
   logic                                  last_chunk;
   logic [WRITE_NUM-1:0]                  ext_ok;
   logic [WRITE_NUM-1:0]                  ext_win;
   logic [WRITE_NUM-1:0]                  ram_we;
   logic [WRITE_NUM-1:0][AW-1:0]          ram_wa;
   logic [WRITE_NUM-1:0][DATA_WIDTH-1:0]  ram_wv;
   logic [READ_NUM-1:0][DATA_WIDTH-1:0]   ram_rv;
   logic [READ_NUM-1:0][DATA_WIDTH-1:0]   rd_data;

   assign init_busy  = (state_q == RF_INIT);
   assign last_chunk = (32'(init_idx_q) + WRITE_NUM >= ENTRY_NUM);

   assign bus.initBusy   = init_busy;
   assign bus.initDone   = init_busy && last_chunk && !bus.initStart;
   assign bus.wrConflict = wr_conflict_q;

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         RF_INIT: begin
            if (bus.initStart) begin
               init_idx_d = '0;
            end else if (last_chunk) begin
               state_d    = RF_READY;
               init_idx_d = '0;
            end else begin
               init_idx_d = init_idx_q + IW'(WRITE_NUM);
            end
         end
         RF_READY: begin
            if (bus.initStart) begin
               state_d    = RF_INIT;
               init_idx_d = '0;
            end
         end
         default: begin
            state_d    = RF_INIT;
            init_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      ext_ok = '0;
      for (int p = 0; p < WRITE_NUM; p++) begin
         ext_ok[p] = !init_busy && bus.we[p] && (32'(bus.wa[p]) < ENTRY_NUM);
      end
   end

   // A port loses to any higher-indexed enabled port targeting the same entry.
   always_comb begin
      ext_win       = ext_ok;
      wr_conflict_d = 1'b0;
      for (int p = 0; p < WRITE_NUM; p++) begin
         for (int q = p + 1; q < WRITE_NUM; q++) begin
            if (ext_ok[p] && ext_ok[q] && (bus.wa[p] == bus.wa[q])) begin
               ext_win[p]    = 1'b0;
               wr_conflict_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ram_we = '0;
      ram_wa = '0;
      ram_wv = '0;
      for (int p = 0; p < WRITE_NUM; p++) begin
         if (init_busy) begin
            ram_we[p] = (32'(init_idx_q) + 32'(p)) < ENTRY_NUM;
            ram_wa[p] = AW'(init_idx_q + IW'(p));
         end else begin
            ram_we[p] = ext_win[p];
            ram_wa[p] = bus.wa[p];
            ram_wv[p] = bus.wv[p];
         end
      end
   end

   multi_port_phys_reg_file_ram #(
      .ENTRY_NUM  (ENTRY_NUM),
      .DATA_WIDTH (DATA_WIDTH),
      .READ_NUM   (READ_NUM),
      .WRITE_NUM  (WRITE_NUM),
      .AW         (AW)
   ) u_ram (
      .clk (clk),
      .we  (ram_we),
      .wa  (ram_wa),
      .wv  (ram_wv),
      .ra  (bus.ra),
      .rv  (ram_rv)
   );

   always_comb begin
      rd_data = ram_rv;
      for (int i = 0; i < READ_NUM; i++) begin
         if (BYPASS_EN != 0) begin
            for (int p = 0; p < WRITE_NUM; p++) begin
               if (ext_win[p] && (bus.wa[p] == bus.ra[i])) begin
                  rd_data[i] = bus.wv[p];
               end
            end
         end
         if (init_busy) begin
            rd_data[i] = '0;
         end
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_rd_comb
         assign bus.rv = rd_data;
      end else begin : g_rd_reg
         logic [READ_NUM-1:0][DATA_WIDTH-1:0] rv_q, rv_d;

         assign rv_d = rd_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rv_q <= '0;
            end else begin
               rv_q <= rv_d;
            end
         end

         assign bus.rv = init_busy ? '0 : rv_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RF_INIT;
         init_idx_q    <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_idx_q    <= init_idx_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

endmodule
`default_nettype wire
